pcpi_issue_ctrl: RTL and testbench

- CPU-side initiator for the PCPI coprocessor interface: accepts one decoded non-native instruction from the core, drives it onto PCPI and collects the coprocessor result.
- Applies the no-responder timeout and returns either a writeback result or an illegal-instruction indication to the core writeback stage.
- Sits between core decode/execute and the PCPI bus shared by the mul/div coprocessors.

---
 rtl/pcpi_pkg.sv | 23 ++
 rtl/pcpi_timeout_cnt.sv | 32 +++
 rtl/pcpi_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_pcpi_issue_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// pcpi_pkg -- shared definitions for the PCPI issue controller.
//   state_t                : issue controller FSM encoding
//   PCPI_OPCODE_OP         : RV32 OP major opcode (carries the M extension)
//   FUNCT7_MULDIV          : funct7 value selecting MUL/DIV/REM
//   DEFAULT_TIMEOUT_CYCLES : default no-responder timeout
//   is_muldiv()            : true for an M-extension OP instruction
package pcpi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [6:0] PCPI_OPCODE_OP         = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV          = 7'b0000001;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[6:0] == PCPI_OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/pcpi_timeout_cnt.sv
// pcpi_timeout_cnt -- clear/enable counter flagging the last cycle of the
// no-responder window.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : force count to 0 (has priority over enable)
//   enable      : advance count by one
//   expired     : count has reached TIMEOUT_CYCLES-1 (combinational)
module pcpi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl -- CPU-side PCPI initiator. Takes one decoded non-native
// instruction from the core, presents it on PCPI, waits for a responder and
// returns either its result or an illegal-instruction indication.
//   clk, resetn       : clock, synchronous active-low reset
//   cmd_*             : instruction + operands from the core (cmd_ready in IDLE)
//   pcpi_*            : shared coprocessor bus (valid/insn/rs1/rs2 registered)
//   rsp_*             : response to writeback, held until rsp_ready
//   perf_*            : optional counters, present only with PCPI_ISSUE_PERF_EN
module pcpi_issue_ctrl
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TO_W           = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_insn,
    input  logic [31:0] cmd_rs1,
    input  logic [31:0] cmd_rs2,
    input  logic [4:0]  cmd_rd_idx,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [4:0]  rsp_rd_idx,
    output logic [31:0] rsp_data,
    output logic        rsp_illegal
`ifdef PCPI_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_busy,
    output logic [15:0] perf_illegal
`endif
);

    state_t state_reg;
    logic   accept;
    logic   to_clear;
    logic   to_enable;
    logic   to_expired;
    logic   timeout;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_ready && cmd_valid;

    // A claimed instruction (pcpi_wait) holds the counter at zero, so once
    // wait drops the full window is available again.
    assign to_clear  = accept || ((state_reg == ST_ISSUE) && pcpi_wait);
    assign to_enable = (state_reg == ST_ISSUE) && !pcpi_wait && !pcpi_ready;
    // Ready in the final window cycle still wins over the timeout.
    assign timeout   = (state_reg == ST_ISSUE) && !pcpi_ready && !pcpi_wait && to_expired;

    pcpi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .clear  (to_clear),
        .enable (to_enable),
        .expired(to_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            pcpi_valid  <= 1'b0;
            pcpi_insn   <= '0;
            pcpi_rs1    <= '0;
            pcpi_rs2    <= '0;
            rsp_valid   <= 1'b0;
            rsp_wr      <= 1'b0;
            rsp_rd_idx  <= '0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        pcpi_insn  <= cmd_insn;
                        pcpi_rs1   <= cmd_rs1;
                        pcpi_rs2   <= cmd_rs2;
                        rsp_rd_idx <= cmd_rd_idx;
                        pcpi_valid <= 1'b1;
                        state_reg  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (pcpi_ready) begin
                        rsp_wr      <= pcpi_wr;
                        rsp_data    <= pcpi_wr ? pcpi_rd : 32'd0;
                        rsp_illegal <= 1'b0;
                        pcpi_valid  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_RESP;
                    end else if (timeout) begin
                        rsp_wr      <= 1'b0;
                        rsp_data    <= 32'd0;
                        rsp_illegal <= 1'b1;
                        pcpi_valid  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    pcpi_valid <= 1'b0;
                    rsp_valid  <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PCPI_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_issued  <= '0;
            perf_busy    <= '0;
            perf_illegal <= '0;
        end else begin
            if (accept)                 perf_issued  <= perf_issued + 1'b1;
            if (state_reg == ST_ISSUE)  perf_busy    <= perf_busy + 1'b1;
            if (timeout)                perf_illegal <= perf_illegal + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// tb_pcpi_issue_ctrl -- directed bench for pcpi_issue_ctrl. The bench plays
// the core and a div/rem coprocessor; expected results are hand-computed.
module tb_pcpi_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
    logic [4:0]  cmd_rd_idx;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait, pcpi_ready;
    logic        rsp_valid, rsp_ready, rsp_wr;
    logic [4:0]  rsp_rd_idx;
    logic [31:0] rsp_data;
    logic        rsp_illegal;
`ifdef PCPI_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_busy;
    logic [15:0] perf_illegal;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pcpi_issue_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_insn   (cmd_insn),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rd_idx (cmd_rd_idx),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wr     (rsp_wr),
        .rsp_rd_idx (rsp_rd_idx),
        .rsp_data   (rsp_data),
        .rsp_illegal(rsp_illegal)
`ifdef PCPI_ISSUE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_busy   (perf_busy),
        .perf_illegal(perf_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // M-extension encoding: rd=x3, rs1=x1, rs2=x2, selectable funct3.
    function automatic logic [31:0] mk_muldiv(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Coprocessor behaviour for DIV/DIVU/REM/REMU (non-zero divisors only).
    function automatic logic [31:0] copro(input logic [31:0] insn, input logic [31:0] a,
                                          input logic [31:0] b);
        case (insn[14:12])
            3'd4:    return $signed(a) / $signed(b);
            3'd5:    return a / b;
            3'd6:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    task automatic idle_bus();
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'd0;
    endtask

    // One full transaction. claim: coprocessor answers after wait_cycles of
    // pcpi_wait. Otherwise an optional stray ready at ready_at (-1 = none).
    task automatic run_txn(input string tag, input logic [31:0] insn, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input bit claim,
                           input int wait_cycles, input int ready_at, input int hold,
                           input int exp_lat, input logic exp_wr, input logic [31:0] exp_data,
                           input logic exp_illegal);
        int n;
        bit stable;
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = a; cmd_rs2 = b; cmd_rd_idx = rd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, "_pcpi_valid"}, 32'(pcpi_valid), 32'd1);
        chk({tag, "_pcpi_insn"}, pcpi_insn, insn);
        n = 0;
        while (!rsp_valid && n < 200) begin
            idle_bus();
            if (claim) begin
                if (n < wait_cycles) pcpi_wait = 1'b1;
                else begin
                    pcpi_ready = 1'b1; pcpi_wr = 1'b1;
                    pcpi_rd = copro(pcpi_insn, pcpi_rs1, pcpi_rs2);
                end
            end else if (n == ready_at) begin
                pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h1234_5678;
            end
            @(posedge clk); #1;
            idle_bus();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_pcpi_valid_low"}, 32'(pcpi_valid), 32'd0);
        chk({tag, "_rsp_wr"}, 32'(rsp_wr), 32'(exp_wr));
        chk({tag, "_rsp_data"}, rsp_data, exp_data);
        chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'(exp_illegal));
        chk({tag, "_rsp_rd_idx"}, 32'(rsp_rd_idx), 32'(rd));
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_illegal !== exp_illegal ||
                cmd_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
        $display("txn %s insn=%08h data=%08h illegal=%0d latency=%0d", tag, insn, rsp_data,
                 rsp_illegal, n);
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_rd_idx = '0; rsp_ready = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Stray ready in IDLE is ignored.
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        idle_bus();
        chk("stray_ready_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("stray_ready_rsp_valid", 32'(rsp_valid), 32'd0);

        run_txn("divu_100_7", mk_muldiv(3'd5), 32'd100, 32'd7, 5'd3, 1'b1, 0, -1, 0,
                1, 1'b1, 32'd14, 1'b0);
        run_txn("div_m7_2", mk_muldiv(3'd4), 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 2, -1, 0,
                3, 1'b1, 32'hFFFF_FFFD, 1'b0);
        run_txn("rem_m7_2", mk_muldiv(3'd6), 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1, 1, -1, 0,
                2, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_txn("unclaimed", 32'h0000_000B, 32'd5, 32'd6, 5'd7, 1'b0, 0, -1, 0,
                16, 1'b0, 32'd0, 1'b1);
        run_txn("long_wait", mk_muldiv(3'd7), 32'd1000, 32'd33, 5'd31, 1'b1, 40, -1, 5,
                41, 1'b1, 32'd10, 1'b0);
        run_txn("ready_cycle15", 32'h0000_000B, 32'd1, 32'd2, 5'd4, 1'b0, 0, 15, 0,
                16, 1'b1, 32'h1234_5678, 1'b0);

        // Reset while a request is outstanding.
        cmd_valid = 1'b1; cmd_insn = 32'h0000_000B; cmd_rs1 = 32'd1; cmd_rs2 = 32'd2;
        cmd_rd_idx = 5'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("midreset_pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;
        run_txn("divu_9_3", mk_muldiv(3'd5), 32'd9, 32'd3, 5'd8, 1'b1, 0, -1, 0,
                1, 1'b1, 32'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
